// File: rtl/ising_pkg.sv
// ising_pkg: shared state encoding and word width for the Ising run sequencer.
package ising_pkg;
    typedef enum logic [2:0] {IDLE, CRST, RUN, RDREQ, PUSH, DONE} run_state_e;
    localparam int SPIN_WORD_W = 32;
endpackage

// File: rtl/ising_run_sched.sv
// ising_run_sched: batches reset/enable/freeze/readback cycles of the Ising core
// and streams each run's spin words to the host result buffer.
module ising_run_sched
    import ising_pkg::*;
#(
    parameter int N          = 64,
    parameter int CYC_W      = 32,
    parameter int RUN_W      = 16,
    parameter int RST_CYCLES = 4,
    localparam int WORDS     = N / SPIN_WORD_W,
    localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   axi_rstn,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [CYC_W-1:0]       cfg_run_cycles,
    input  logic [RUN_W-1:0]       cfg_num_runs,
    output logic                   busy,
    output logic                   done,
    output logic [RUN_W-1:0]       runs_done,
    output logic                   core_rstn,
    output logic                   core_en,
    output logic                   spin_rd_req,
    output logic [IDX_W-1:0]       spin_rd_idx,
    input  logic                   spin_rd_ack,
    input  logic [SPIN_WORD_W-1:0] spin_rd_data,
    output logic                   res_valid,
    output logic [SPIN_WORD_W-1:0] res_data,
    output logic                   res_last,
    input  logic                   res_ready
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e             state_q;
    logic [CYC_W-1:0]       run_cycles_q, cyc_cnt_q;
    logic [RUN_W-1:0]       num_runs_q, runs_done_q;
    logic [RC_W-1:0]        rst_cnt_q;
    logic                   busy_q, done_q, core_rstn_q, core_en_q, spin_rd_req_q;
    logic                   res_valid_q, res_last_q;
    logic [IDX_W-1:0]       spin_rd_idx_q;
    logic [SPIN_WORD_W-1:0] res_data_q;

    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            state_q       <= IDLE;
            run_cycles_q  <= '0;
            cyc_cnt_q     <= '0;
            num_runs_q    <= '0;
            runs_done_q   <= '0;
            rst_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            core_rstn_q   <= 1'b0;
            core_en_q     <= 1'b0;
            spin_rd_req_q <= 1'b0;
            spin_rd_idx_q <= '0;
            res_valid_q   <= 1'b0;
            res_last_q    <= 1'b0;
            res_data_q    <= '0;
        end else if (cfg_abort && state_q != IDLE) begin
            // abort drops any in-flight word and leaves the core released but frozen
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            core_en_q     <= 1'b0;
            core_rstn_q   <= 1'b1;
            spin_rd_req_q <= 1'b0;
            spin_rd_idx_q <= '0;
            res_valid_q   <= 1'b0;
            res_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    core_rstn_q <= 1'b1;
                    if (cfg_start && !cfg_abort) begin
                        run_cycles_q <= cfg_run_cycles;
                        num_runs_q   <= cfg_num_runs;
                        done_q       <= 1'b0;
                        runs_done_q  <= '0;
                        busy_q       <= 1'b1;
                        rst_cnt_q    <= '0;
                        core_rstn_q  <= (cfg_num_runs == '0);
                        state_q      <= (cfg_num_runs == '0) ? DONE : CRST;
                    end
                end
                CRST: begin
                    rst_cnt_q <= rst_cnt_q + 1'b1;
                    cyc_cnt_q <= '0;
                    if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                        core_rstn_q   <= 1'b1;
                        core_en_q     <= (run_cycles_q != '0);
                        spin_rd_req_q <= (run_cycles_q == '0);
                        state_q       <= (run_cycles_q == '0) ? RDREQ : RUN;
                    end
                end
                RUN: begin
                    cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    if (cyc_cnt_q == run_cycles_q - CYC_W'(1)) begin
                        core_en_q     <= 1'b0;
                        spin_rd_req_q <= 1'b1;
                        state_q       <= RDREQ;
                    end
                end
                RDREQ: begin
                    if (spin_rd_ack) begin
                        res_data_q    <= spin_rd_data;
                        spin_rd_req_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_last_q    <= (spin_rd_idx_q == IDX_W'(WORDS - 1));
                        state_q       <= PUSH;
                    end
                end
                PUSH: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_last_q  <= 1'b0;
                        if (res_last_q) begin
                            spin_rd_idx_q <= '0;
                            runs_done_q   <= runs_done_q + RUN_W'(1);
                            rst_cnt_q     <= '0;
                            core_rstn_q   <= !(runs_done_q + RUN_W'(1) < num_runs_q);
                            state_q       <= (runs_done_q + RUN_W'(1) < num_runs_q) ? CRST : DONE;
                        end else begin
                            spin_rd_idx_q <= spin_rd_idx_q + 1'b1;
                            spin_rd_req_q <= 1'b1;
                            state_q       <= RDREQ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign runs_done   = runs_done_q;
    assign core_rstn   = core_rstn_q;
    assign core_en     = core_en_q;
    assign spin_rd_req = spin_rd_req_q;
    assign spin_rd_idx = spin_rd_idx_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_last    = res_last_q;
endmodule

// File: tb/tb_ising_run_sched.sv
// tb_ising_run_sched: randomized batches against a queue scoreboard and per-batch
// arithmetic expectations (words, enable cycles, reset pulses, latency).
module tb_ising_run_sched;
    import ising_pkg::*;
    localparam int N     = 64;
    localparam int WORDS = N / 32;
    localparam int RSTC  = 4;
    localparam int LIM   = 5000;

    logic        clk, axi_rstn, cfg_start, cfg_abort;
    logic [31:0] cfg_run_cycles;
    logic [15:0] cfg_num_runs;
    logic        busy, done, core_rstn, core_en, spin_rd_req, spin_rd_ack;
    logic [15:0] runs_done;
    logic [0:0]  spin_rd_idx;
    logic [31:0] spin_rd_data, res_data;
    logic        res_valid, res_last, res_ready;

    ising_run_sched #(.N(N), .CYC_W(32), .RUN_W(16), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .axi_rstn(axi_rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_run_cycles(cfg_run_cycles), .cfg_num_runs(cfg_num_runs),
        .busy(busy), .done(done), .runs_done(runs_done),
        .core_rstn(core_rstn), .core_en(core_en),
        .spin_rd_req(spin_rd_req), .spin_rd_idx(spin_rd_idx),
        .spin_rd_ack(spin_rd_ack), .spin_rd_data(spin_rd_data),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0, miscompares = 0;
    logic [32:0] sb[$];
    int ack_dly = 0, rmode = 0, exp_rc = 0;
    bit chk_on = 1'b1;
    int wcnt, dcnt, en_run, en_total, rlow, pulses, words_out;
    logic prev_rstn = 1'b1, prev_hold = 1'b0, prev_last;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout/empty expected event", name);
    endtask

    task automatic clr();
        wcnt = 0; dcnt = 0; en_run = 0; en_total = 0; rlow = 0; pulses = 0; words_out = 0;
        prev_hold = 1'b0;
        sb.delete();
    endtask

    // core read-side model, result sink and monitor, all on the falling edge
    initial begin
        logic [32:0] e;
        forever @(negedge clk) begin
            if (spin_rd_ack) spin_rd_ack = 1'b0;
            else if (spin_rd_req && axi_rstn) begin
                if (dcnt >= ack_dly) begin
                    check("rd_idx", spin_rd_idx, wcnt % WORDS);
                    spin_rd_data = $urandom;
                    spin_rd_ack = 1'b1;
                    sb.push_back({(wcnt % WORDS) == WORDS - 1, spin_rd_data});
                    wcnt++;
                    dcnt = 0;
                end else dcnt++;
            end
            res_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~res_ready :
                        (rmode == 2) ? 1'($urandom % 2) : 1'b0;
            if (axi_rstn) begin
                if (res_valid) begin
                    if (prev_hold && chk_on) begin
                        check("hold_data", res_data, prev_data);
                        check("hold_last", res_last, prev_last);
                    end
                    if (res_ready) begin
                        if (sb.size() == 0) fail("sb_pop");
                        else begin
                            e = sb.pop_front();
                            check("res_data", res_data, e[31:0]);
                            check("res_last", res_last, e[32]);
                        end
                        words_out++;
                        prev_hold = 1'b0;
                    end else begin
                        prev_hold = 1'b1;
                        prev_data = res_data;
                        prev_last = res_last;
                    end
                end else begin
                    if (prev_hold && chk_on) check("valid_held", res_valid, 1);
                    prev_hold = 1'b0;
                end
                if (core_en) en_run++;
                else if (en_run > 0) begin
                    if (chk_on) check("en_len", en_run, exp_rc);
                    en_total += en_run;
                    en_run = 0;
                end
                if (busy && !core_rstn) begin
                    rlow++;
                    if (prev_rstn) pulses++;
                end
                prev_rstn = core_rstn;
            end
        end
    end

    task automatic start(input int rc, input int nr, input int dly, input int rm);
        clr();
        ack_dly = dly; rmode = rm; exp_rc = rc; chk_on = 1'b1;
        cfg_run_cycles = 32'(rc);
        cfg_num_runs = 16'(nr);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic batch(input int rc, input int nr, input int dly, input int rm, input bit poke);
        int k, first_en;
        start(rc, nr, dly, rm);
        first_en = -1;
        for (k = 1; k <= LIM; k++) begin
            if (!busy) break;
            if (first_en < 0 && core_en) first_en = k;
            if (poke && k == 3) begin
                cfg_start = 1'b1; cfg_num_runs = 16'd5; cfg_run_cycles = 32'd1;
            end
            if (poke && k == 4) cfg_start = 1'b0;
            @(negedge clk);
        end
        if (k > LIM) fail("batch_timeout");
        if (nr == 0) check("zero_runs_len", k, 2);
        @(negedge clk);
        check("done", done, 1);
        check("runs_done", runs_done, nr);
        check("words", words_out, nr * WORDS);
        check("en_total", en_total, nr * rc);
        check("rst_pulses", pulses, nr);
        check("rst_low", rlow, nr * RSTC);
        check("sb_left", sb.size(), 0);
        if (nr > 0 && rc > 0) check("en_latency", first_en, RSTC + 1);
    endtask

    task automatic check_reset_outs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_runs", runs_done, 0);
        check("rst_core_rstn", core_rstn, 0);
        check("rst_core_en", core_en, 0);
        check("rst_req", spin_rd_req, 0);
        check("rst_idx", spin_rd_idx, 0);
        check("rst_valid", res_valid, 0);
        check("rst_last", res_last, 0);
        check("rst_data", res_data, 0);
    endtask

    initial begin
        int k;
        axi_rstn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_run_cycles = '0; cfg_num_runs = '0;
        spin_rd_ack = 1'b0; spin_rd_data = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outs();
        axi_rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_core_rstn", core_rstn, 1);

        batch(10, 1, 0, 0, 0);
        batch(6, 3, 5, 1, 1);
        batch(0, 1, 0, 0, 0);
        batch(10, 0, 0, 0, 0);

        // abort on the fifth enabled cycle of a long run
        start(100, 1, 0, 0);
        for (k = 0; k < LIM && !core_en; k++) @(negedge clk);
        if (k >= LIM) fail("abort_wait_en");
        repeat (4) @(negedge clk);
        chk_on = 1'b0;
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_en", core_en, 0);
        check("abort_rstn", core_rstn, 1);
        check("abort_done", done, 0);
        check("abort_runs", runs_done, 0);
        check("abort_valid", res_valid, 0);
        repeat (5) @(negedge clk);
        check("abort_words", words_out, 0);
        batch(7, 1, 1, 2, 0);

        // reset while a word is stalled in PUSH
        start(3, 2, 0, 3);
        chk_on = 1'b0;
        for (k = 0; k < LIM && !res_valid; k++) @(negedge clk);
        if (k >= LIM) fail("reset_wait_valid");
        axi_rstn = 1'b0;
        @(negedge clk);
        check_reset_outs();
        axi_rstn = 1'b1;
        rmode = 0;
        repeat (2) @(negedge clk);
        check("post_rst_words", words_out, 0);
        check("post_rst_busy", busy, 0);

        repeat (6) batch($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 4),
                         $urandom_range(0, 2), 1'($urandom % 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
